mtrx_ctrl_regs: RTL and testbench
=================================

// Module: mtrx_ctrl_regs
// PURPOSE
//  System-bus register block for multi-panel LED matrix arrays. Sits between the GPMC target
//  (sb_* strobes) and NUM_PANELS matrix drivers; generalises the single-panel register set with
//  per-panel/broadcast pixel writes, programmable address stride and a handshaked buffer swap.
// PARAMETERS
//  NUM_PANELS  6       matrix drivers served; PSEL_W = $clog2(NUM_PANELS) (min 1)
//  ADDR_W      14      pixel address width per panel
//  DATA_W      12      pixel data width (sb_wr_data[DATA_W-1:0])
//  LEVEL_W     9       brightness level width
//  LEVEL_RST   9'h100  level reset value
// PORTS
//  clk          in   1             system clock (all logic)
//  rst          in   1             synchronous active-high reset
//  sb_wr        in   1             bus write strobe, 1 cycle
//  sb_rd        in   1             bus read strobe, 1 cycle
//  sb_addr      in   16            word address (sb_addr[16:1] in bus terms)
//  sb_wr_data   in   16            write data
//  sb_rd_data   out  16            read data, registered
//  pix_wr       out  NUM_PANELS    per-panel pixel write pulse
//  pix_wr_addr  out  ADDR_W        pixel write address
//  pix_wr_data  out  DATA_W        pixel write data
//  buf_select   out  1             requested display buffer
//  buf_current  in   1             buffer in use by drivers, already synchronised to clk
//  level        out  LEVEL_W       brightness level
//  test_pin     out  1             debug output
//  irq          out  1             swap-complete interrupt
// BEHAVIOUR
//  Reset: sb_rd_data=16'hffff, pix_wr=0, pix_wr_addr=0, pix_wr_data=0, buf_select=0,
//   level=LEVEL_RST, test_pin=0, irq=0, scratch=0, pix_addr=0, panel=0, bcast=0, stride=1,
//   pending=0.
//  Map (W=write effect, R=read value; unmapped read -> 0, unmapped write ignored):
//   0-3 scratch R/W 16b | 4-7 R const 16'hdead,16'hbeef,16'hcafe,16'hfeed
//   8  PIX_ADDR R/W [ADDR_W-1:0]
//   9  PIX_DATA W: next cycle pix_wr pulses 1 cycle, pix_wr_addr=pix_addr,
//      pix_wr_data=sb_wr_data[DATA_W-1:0]; pix_addr += stride, modulo 2^ADDR_W (wraps)
//   10 SWAP W: buf_select<=bit0, pending<=1; R {13'b0,pending,buf_current,buf_select}
//   11 LEVEL R/W [LEVEL_W-1:0] | 12 TEST R/W bit0 -> test_pin
//   13 PANEL R/W {bcast[15], panel[PSEL_W-1:0]}
//   14 STRIDE R/W [ADDR_W-1:0]; writing 0 stores 1
//   15 STATUS R {14'b0,irq,pending}; W bit0=1 clears irq
//  Pixel write targets: bcast=1 -> pix_wr all ones; else one-hot pix_wr[panel];
//   panel>=NUM_PANELS -> pix_wr stays 0 but pix_addr still advances.
//  Read latency 1: sb_rd at cycle N -> sb_rd_data valid N+1, held until next sb_rd.
//  sb_rd and sb_wr same cycle, same reg: read returns pre-write value; both take effect.
//  Swap handshake: pending clears on first cycle buf_current==buf_select with pending=1
//   (not the write cycle itself). SWAP write while pending: buf_select updates, pending
//   stays 1, completion measured against new value.
//  Back-to-back PIX_DATA writes each cycle: one pix_wr per write, consecutive strided addrs.
//  rst mid-burst: pix_wr low next cycle, all state to reset values; no partial write.
// CONFIGURATION
//  MTRX_SWAP_IRQ_EN defined: irq sets on cycle pending clears 1->0; cleared by STATUS write
//   bit0=1; set and clear same cycle -> set wins.
//  Not defined: irq tied 0, STATUS bit1 reads 0, STATUS writes ignored.
// TESTING
//  rst; read 4..7,8,11,14 -> dead,beef,cafe,feed,0,0x100,1; unmapped read 0x20 -> 0.
//  PIX_ADDR=0x3ffe, STRIDE=1, PANEL=2, PIX_DATA x3 (0xabc,0x123,0x456) -> pix_wr=6'b000100 at
//   addr 0x3ffe,0x3fff,0x0000 with matching data (wrap).
//  PANEL=0x8000, STRIDE=0 then read 14 -> 1; one PIX_DATA -> pix_wr=6'b111111; PANEL=7 ->
//   pix_wr stays 0, PIX_ADDR read shows +1.
//  SWAP=1 with buf_current=0 -> STATUS=1; buf_current->1 -> pending 0 next cycle, irq=1
//   (with MTRX_SWAP_IRQ_EN); STATUS write 1 -> irq 0; without macro irq stays 0.
//  SWAP=1, then SWAP=0 before buf_current changes -> pending stays 1 until buf_current==0.
//  assert rst mid PIX_DATA burst -> pix_wr 0 next cycle, PIX_ADDR reads 0, level=0x100.

Source files
------------

// File: rtl/mtrx_ctrl_regs.sv
// Bus register block for a multi-panel LED matrix array: pixel writes, brightness, buffer swap.
// Define MTRX_SWAP_IRQ_EN to build the swap-complete interrupt; otherwise irq is tied low.
module mtrx_ctrl_regs #(
  parameter int NUM_PANELS = 6,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 12,
  parameter int LEVEL_W    = 9,
  parameter logic [LEVEL_W-1:0] LEVEL_RST = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sb_wr,
  input  logic                  sb_rd,
  input  logic [15:0]           sb_addr,
  input  logic [15:0]           sb_wr_data,
  output logic [15:0]           sb_rd_data,
  output logic [NUM_PANELS-1:0] pix_wr,
  output logic [ADDR_W-1:0]     pix_wr_addr,
  output logic [DATA_W-1:0]     pix_wr_data,
  output logic                  buf_select,
  input  logic                  buf_current,
  output logic [LEVEL_W-1:0]    level,
  output logic                  test_pin,
  output logic                  irq
);

  localparam int PSEL_W = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;

  logic [15:0]           scratch [4];
  logic [ADDR_W-1:0]     pix_addr;
  logic [ADDR_W-1:0]     stride;
  logic [PSEL_W-1:0]     panel;
  logic                  bcast;
  logic                  pending;
  logic                  irq_q;
  logic                  swap_done;
  logic                  mapped;
  logic [3:0]            reg_idx;
  logic [15:0]           rd_val;
  logic [NUM_PANELS-1:0] tgt_mask;
  logic                  wr_sel;
  logic                  wr_pix_addr, wr_pix_data, wr_swap, wr_level;
  logic                  wr_test, wr_panel, wr_stride;

  assign mapped      = (sb_addr[15:4] == 12'd0);
  assign reg_idx     = sb_addr[3:0];
  assign wr_sel      = sb_wr && mapped;
  assign wr_pix_addr = wr_sel && (reg_idx == 4'd8);
  assign wr_pix_data = wr_sel && (reg_idx == 4'd9);
  assign wr_swap     = wr_sel && (reg_idx == 4'd10);
  assign wr_level    = wr_sel && (reg_idx == 4'd11);
  assign wr_test     = wr_sel && (reg_idx == 4'd12);
  assign wr_panel    = wr_sel && (reg_idx == 4'd13);
  assign wr_stride   = wr_sel && (reg_idx == 4'd14);

  // A new SWAP write restarts the handshake, so it takes priority over completion.
  assign swap_done = pending && (buf_current == buf_select) && !wr_swap;

  // Panel selects beyond NUM_PANELS match no bit, so the write is silently dropped.
  always_comb begin
    tgt_mask = '0;
    for (int i = 0; i < NUM_PANELS; i++) begin
      tgt_mask[i] = bcast || (panel == PSEL_W'(i));
    end
  end

  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (reg_idx)
        4'd0, 4'd1, 4'd2, 4'd3: rd_val = scratch[reg_idx[1:0]];
        4'd4:  rd_val = 16'hdead;
        4'd5:  rd_val = 16'hbeef;
        4'd6:  rd_val = 16'hcafe;
        4'd7:  rd_val = 16'hfeed;
        4'd8:  rd_val = 16'(pix_addr);
        4'd10: rd_val = {13'd0, pending, buf_current, buf_select};
        4'd11: rd_val = 16'(level);
        4'd12: rd_val = {15'd0, test_pin};
        4'd13: begin
          rd_val[15]         = bcast;
          rd_val[PSEL_W-1:0] = panel;
        end
        4'd14: rd_val = 16'(stride);
        4'd15: rd_val = {14'd0, irq_q, pending};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_rd_data  <= 16'hffff;
      pix_wr      <= '0;
      pix_wr_addr <= '0;
      pix_wr_data <= '0;
      buf_select  <= 1'b0;
      level       <= LEVEL_RST;
      test_pin    <= 1'b0;
      pix_addr    <= '0;
      stride      <= ADDR_W'(1);
      panel       <= '0;
      bcast       <= 1'b0;
      pending     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      if (sb_rd) begin
        sb_rd_data <= rd_val;
      end
      pix_wr <= '0;
      if (wr_sel && (reg_idx[3:2] == 2'd0)) begin
        scratch[reg_idx[1:0]] <= sb_wr_data;
      end
      if (wr_pix_data) begin
        pix_wr      <= tgt_mask;
        pix_wr_addr <= pix_addr;
        pix_wr_data <= sb_wr_data[DATA_W-1:0];
        pix_addr    <= pix_addr + stride;
      end else if (wr_pix_addr) begin
        pix_addr <= sb_wr_data[ADDR_W-1:0];
      end
      if (wr_swap) begin
        buf_select <= sb_wr_data[0];
        pending    <= 1'b1;
      end else if (swap_done) begin
        pending <= 1'b0;
      end
      if (wr_level) begin
        level <= sb_wr_data[LEVEL_W-1:0];
      end
      if (wr_test) begin
        test_pin <= sb_wr_data[0];
      end
      if (wr_panel) begin
        bcast <= sb_wr_data[15];
        panel <= sb_wr_data[PSEL_W-1:0];
      end
      if (wr_stride) begin
        stride <= (sb_wr_data[ADDR_W-1:0] == '0) ? ADDR_W'(1) : sb_wr_data[ADDR_W-1:0];
      end
    end
  end

`ifdef MTRX_SWAP_IRQ_EN
  logic wr_status;
  assign wr_status = wr_sel && (reg_idx == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (swap_done) begin
      irq_q <= 1'b1;
    end else if (wr_status && sb_wr_data[0]) begin
      irq_q <= 1'b0;
    end
  end
`else
  assign irq_q = 1'b0;
`endif

  assign irq = irq_q;

endmodule

// File: tb/tb_mtrx_ctrl_regs.sv
// Scoreboard bench for mtrx_ctrl_regs: bus reads and pixel pulses are checked against queued expectations.
module tb_mtrx_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sb_wr = 1'b0;
  logic        sb_rd = 1'b0;
  logic [15:0] sb_addr = '0;
  logic [15:0] sb_wr_data = '0;
  logic        buf_current = 1'b0;
  logic [15:0] sb_rd_data;
  logic [5:0]  pix_wr;
  logic [13:0] pix_wr_addr;
  logic [11:0] pix_wr_data;
  logic        buf_select;
  logic [8:0]  level;
  logic        test_pin;
  logic        irq;

`ifdef MTRX_SWAP_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  mtrx_ctrl_regs dut (
    .clk(clk), .rst(rst), .sb_wr(sb_wr), .sb_rd(sb_rd), .sb_addr(sb_addr),
    .sb_wr_data(sb_wr_data), .sb_rd_data(sb_rd_data), .pix_wr(pix_wr),
    .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data), .buf_select(buf_select),
    .buf_current(buf_current), .level(level), .test_pin(test_pin), .irq(irq)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] rdExpQ [$];
  string       rdTagQ [$];
  logic [5:0]  pixMaskQ [$];
  logic [13:0] pixAddrQ [$];
  logic [11:0] pixDataQ [$];
  logic        rdSeen = 1'b0;
  logic        pixSeen = 1'b0;
  string       monTag;
  logic [15:0] monExp;
  logic [5:0]  monMask;
  logic [13:0] monAddr;
  logic [11:0] monData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remember which cycles carried a read or pixel write so the next falling edge can check the result.
  always @(posedge clk) begin
    rdSeen  <= sb_rd && !rst;
    pixSeen <= sb_wr && (sb_addr == 16'd9) && !rst;
  end

  always @(negedge clk) begin
    if (rdSeen) begin
      if (rdExpQ.size() == 0) begin
        checkOutput("rd_queue_underflow", rdExpQ.size(), 1);
      end else begin
        monTag = rdTagQ.pop_front();
        monExp = rdExpQ.pop_front();
        checkOutput(monTag, sb_rd_data, monExp);
      end
    end
    if (pixSeen) begin
      if (pixMaskQ.size() == 0) begin
        checkOutput("pix_queue_underflow", pixMaskQ.size(), 1);
      end else begin
        monMask = pixMaskQ.pop_front();
        monAddr = pixAddrQ.pop_front();
        monData = pixDataQ.pop_front();
        checkOutput("pix_wr", pix_wr, monMask);
        if (monMask != 6'd0) begin
          checkOutput("pix_wr_addr", pix_wr_addr, monAddr);
          checkOutput("pix_wr_data", pix_wr_data, monData);
        end
      end
    end else begin
      checkOutput("pix_idle", pix_wr, 6'd0);
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst = r; sb_wr = w; sb_rd = rd; sb_addr = a; sb_wr_data = d;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic busRead(input logic [15:0] a, input logic [15:0] exp, input string tag);
    rdExpQ.push_back(exp);
    rdTagQ.push_back(tag);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 16'd0);
  endtask

  task automatic pixWrite(input logic [15:0] d, input logic [5:0] m, input logic [13:0] a);
    pixMaskQ.push_back(m);
    pixAddrQ.push_back(a);
    pixDataQ.push_back(d[11:0]);
    busWrite(16'd9, d);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic setBufCurrent(input logic v);
    @(posedge clk);
    #1;
    buf_current = v; sb_wr = 1'b0; sb_rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_rd_data", sb_rd_data, 16'hffff);
    checkOutput("rst_pix_wr", pix_wr, 6'd0);
    checkOutput("rst_level", level, 9'h100);
    checkOutput("rst_buf_select", buf_select, 1'b0);
    checkOutput("rst_test_pin", test_pin, 1'b0);
    checkOutput("rst_irq", irq, 1'b0);

    busRead(16'd4, 16'hdead, "rd_const4");
    busRead(16'd5, 16'hbeef, "rd_const5");
    busRead(16'd6, 16'hcafe, "rd_const6");
    busRead(16'd7, 16'hfeed, "rd_const7");
    busRead(16'd8, 16'h0000, "rd_pix_addr_rst");
    busRead(16'd11, 16'h0100, "rd_level_rst");
    busRead(16'd14, 16'h0001, "rd_stride_rst");
    busRead(16'h0020, 16'h0000, "rd_unmapped");
    busRead(16'd15, 16'h0000, "rd_status_rst");

    // Same-cycle read and write of one register returns the old value.
    busWrite(16'd0, 16'h1234);
    busWrite(16'd3, 16'ha5a5);
    rdExpQ.push_back(16'h1234);
    rdTagQ.push_back("rd_wr_same_cycle");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0, 16'h5678);
    busRead(16'd0, 16'h5678, "rd_scratch0");
    busRead(16'd3, 16'ha5a5, "rd_scratch3");

    // Single-panel burst wrapping past the top of the pixel address space.
    busWrite(16'd8, 16'h3ffe);
    busWrite(16'd14, 16'd1);
    busWrite(16'd13, 16'd2);
    pixWrite(16'h0abc, 6'b000100, 14'h3ffe);
    pixWrite(16'h0123, 6'b000100, 14'h3fff);
    pixWrite(16'h0456, 6'b000100, 14'h0000);
    busRead(16'd8, 16'h0001, "rd_pix_addr_wrap");

    busWrite(16'd13, 16'h8000);
    busWrite(16'd14, 16'd0);
    busRead(16'd14, 16'h0001, "rd_stride_zero");
    busRead(16'd13, 16'h8000, "rd_panel_bcast");
    pixWrite(16'h0777, 6'b111111, 14'h0001);
    busWrite(16'd13, 16'd7);
    pixWrite(16'h0111, 6'b000000, 14'h0002);
    busRead(16'd8, 16'h0003, "rd_pix_addr_dropped");
    busWrite(16'd13, 16'd0);
    busWrite(16'd14, 16'd5);
    pixWrite(16'h0222, 6'b000001, 14'h0003);
    busRead(16'd8, 16'h0008, "rd_pix_addr_stride5");

    busWrite(16'd11, 16'h01ff);
    busWrite(16'd12, 16'h0001);
    busRead(16'd11, 16'h01ff, "rd_level");
    busRead(16'd12, 16'h0001, "rd_test");
    idle(1);
    @(negedge clk);
    checkOutput("level_out", level, 9'h1ff);
    checkOutput("test_pin_out", test_pin, 1'b1);

    // Swap handshake with completion interrupt.
    busWrite(16'd10, 16'd1);
    busRead(16'd15, 16'h0001, "rd_status_pending");
    busRead(16'd10, 16'h0005, "rd_swap_pending");
    idle(1);
    @(negedge clk);
    checkOutput("buf_select_1", buf_select, 1'b1);
    setBufCurrent(1'b1);
    idle(2);
    @(negedge clk);
    checkOutput("irq_after_swap", irq, IRQ_EN);
    busRead(16'd15, {14'd0, IRQ_EN, 1'b0}, "rd_status_done");
    busWrite(16'd15, 16'd1);
    busRead(16'd15, 16'h0000, "rd_status_cleared");
    idle(1);
    @(negedge clk);
    checkOutput("irq_cleared", irq, 1'b0);

    // Retargeting a pending swap: completion follows the newest request.
    busWrite(16'd10, 16'd1);
    busWrite(16'd10, 16'd0);
    busRead(16'd15, 16'h0001, "rd_status_retarget");
    busRead(16'd10, 16'h0006, "rd_swap_retarget");
    idle(2);
    @(negedge clk);
    checkOutput("irq_retarget_wait", irq, 1'b0);
    setBufCurrent(1'b0);
    idle(2);
    busRead(16'd15, {14'd0, IRQ_EN, 1'b0}, "rd_status_retarget_done");
    busWrite(16'd15, 16'd1);

    // Reset arrives on the third write of a burst; that write must not appear.
    busWrite(16'd13, 16'd1);
    busWrite(16'd14, 16'd1);
    busWrite(16'd8, 16'h0010);
    pixWrite(16'h00a1, 6'b000010, 14'h0010);
    pixWrite(16'h00a2, 6'b000010, 14'h0011);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd9, 16'h00a3);
    idle(2);
    @(negedge clk);
    checkOutput("level_after_rst", level, 9'h100);
    checkOutput("buf_select_after_rst", buf_select, 1'b0);
    busRead(16'd8, 16'h0000, "rd_pix_addr_after_rst");
    busRead(16'd11, 16'h0100, "rd_level_after_rst");
    busRead(16'd13, 16'h0000, "rd_panel_after_rst");
    busRead(16'd0, 16'h0000, "rd_scratch_after_rst");
    idle(3);

    checkOutput("rd_queue_empty", rdExpQ.size(), 0);
    checkOutput("pix_queue_empty", pixMaskQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
